// File: rtl/arb_pkg.sv
// arb_pkg: shared constants, request-vector type and one-hot/index helpers for the round-robin arbiter.
package arb_pkg;
  localparam int NREQ_MAX = 16;
  localparam int IDX_W = $clog2(NREQ_MAX);
  typedef logic [NREQ_MAX-1:0] reqvec_t;
  function automatic reqvec_t onehot(input logic [IDX_W-1:0] idx);
    onehot = reqvec_t'(1) << idx;
  endfunction
  function automatic logic [IDX_W-1:0] index(input reqvec_t vec);
    index = '0;
    for (int k = NREQ_MAX - 1; k >= 0; k--)
      if (vec[k]) index = IDX_W'(k);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick; rotates requests to start after i_ptr, priority-encodes, rotates back.
module rr_pick
  import arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_onehot,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);
  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [IW:0]       w_off, w_sum;
  logic [IW-1:0]     w_enc;
  always_comb begin
    w_off = (i_ptr == IW'(NREQ - 1)) ? '0 : {1'b0, i_ptr} + 1'b1;
    w_dbl = {i_valid, i_valid} >> w_off;
    w_rot = w_dbl[NREQ-1:0];
    w_enc = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (w_rot[k]) w_enc = IW'(k);
    w_sum = {1'b0, w_enc} + w_off;
    // Rotating back is a modulo-NREQ add; w_sum never reaches 2*NREQ.
    o_idx = (w_sum >= (IW+1)'(NREQ)) ? IW'(w_sum - (IW+1)'(NREQ)) : w_sum[IW-1:0];
    o_any = |i_valid;
    o_onehot = o_any ? NREQ'(onehot(IDX_W'(o_idx))) : '0;
  end
endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter muxing NREQ valid/ready requesters into one registered output stage.
// Optional ARB_LOCK_EN adds ReqLock so a requester can hold the arbiter across several beats.
module rr_mux_arbiter
  import arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int WIDTH = 8,
  localparam int IW = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       ReqValid,
  input  logic [NREQ*WIDTH-1:0] ReqData,
  output logic [NREQ-1:0]       ReqReady,
  output logic                  OutValid,
  output logic [WIDTH-1:0]      OutData,
  input  logic                  OutReady,
`ifdef ARB_LOCK_EN
  input  logic [NREQ-1:0]       ReqLock,
`endif
  output logic [NREQ-1:0]       Grant
);
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [NREQ-1:0]  r_grant;
  logic [IW-1:0]    r_ptr;
  logic             w_accept, w_any, w_fire;
  logic [NREQ-1:0]  w_cand, w_onehot;
  logic [IW-1:0]    w_idx;
  logic [WIDTH-1:0] w_data;
`ifdef ARB_LOCK_EN
  logic             r_lock;
  logic [IW-1:0]    r_lock_id;
  assign w_cand = r_lock ? (ReqValid & NREQ'(onehot(IDX_W'(r_lock_id)))) : ReqValid;
`else
  assign w_cand = ReqValid;
`endif
  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_valid  (w_cand),
    .i_ptr    (r_ptr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );
  assign w_accept = ~r_valid | OutReady;
  assign w_fire   = w_accept & w_any;
  assign ReqReady = w_accept ? w_onehot : '0;
  always_comb begin
    w_data = '0;
    for (int k = 0; k < NREQ; k++)
      w_data = w_data | (ReqData[k*WIDTH +: WIDTH] & {WIDTH{w_onehot[k]}});
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_grant <= '0;
      r_ptr   <= IW'(NREQ - 1);
    end else if (w_fire) begin
      r_valid <= 1'b1;
      r_data  <= w_data;
      r_grant <= w_onehot;
      r_ptr   <= w_idx;
    end else if (OutReady) begin
      r_valid <= 1'b0;
    end
  end
`ifdef ARB_LOCK_EN
  // While locked only r_lock_id can fire, so reloading from the winner both sets and clears the lock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lock    <= 1'b0;
      r_lock_id <= '0;
    end else if (w_fire) begin
      r_lock    <= ReqLock[w_idx];
      r_lock_id <= w_idx;
    end
  end
`endif
  assign OutValid = r_valid;
  assign OutData  = r_data;
  assign Grant    = r_grant;
endmodule
